// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store sequencer between the decoder's memory
// controls and a ready/ack data-memory bus.
//
// Each access runs IDLE -> ACCESS -> RESP. The controller raises a
// word-aligned bus request with byte enables and lane-replicated store data.
// It stalls the core until the bus acknowledges, then returns a sign- or
// zero-extended load result. It flags misaligned or timed-out accesses with
// err alongside the one-cycle done pulse.
//
// Optional feature macro: MISALIGN_SPLIT_EN
//   When defined, misaligned halfword/word accesses are split into two bus
//   beats (ACCESS then ACCESS1) instead of being rejected with err.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req_valid           memory instruction present in execute
//   mem_rw              0 = load, 1 = store
//   load_op             0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (3/6/7 act as LW)
//   write_op            0 SB, 1 SH, 2/3 SW
//   addr, wdata         effective address and store data
//   stall               hold the PC/pipeline while the access is in flight
//   done, err           one-cycle completion pulse and its error flag
//   rdata               last successfully loaded, extended value
//   bus_req, bus_we     bus request and write strobe
//   bus_addr, bus_be    word address ([1:0] = 0) and byte enables
//   bus_wdata           lane-aligned store data
//   bus_ack, bus_rdata  bus completion and read data (valid with ack)
module lsu_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_rw,
  input  logic [2:0]        load_op,
  input  logic [1:0]        write_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
`ifdef MISALIGN_SPLIT_EN
    ACCESS1,
`endif
    RESP
  } state_t;

  // Counter value seen during the last ACCESS cycle allowed before abort
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state, state_next;
  logic              rw_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [7:0]        cnt;

  logic [1:0]        size_in;
  logic              misalign_in, timeout, last_beat;
  logic [1:0]        off;
  logic [ADDR_W-1:0] word_addr;
  logic [3:0]        size_mask;
  logic [31:0]       rep_wdata, raw, ext;

  assign rdata   = rdata_q;
  assign timeout = (cnt == TO_LAST);

  // Access size (0 byte, 1 half, 2 word) and alignment of the incoming request
  always_comb begin
    size_in = 2'd2;
    if (mem_rw) begin
      if (write_op == 2'd0)      size_in = 2'd0;
      else if (write_op == 2'd1) size_in = 2'd1;
    end else begin
      if (load_op[1:0] == 2'd0)      size_in = 2'd0;
      else if (load_op[1:0] == 2'd1) size_in = 2'd1;
    end
    misalign_in = ((size_in == 2'd1) && addr[0]) ||
                  ((size_in == 2'd2) && (addr[1:0] != 2'b00));
  end

  // Lane mask, word address and replicated store data for the latched access
  always_comb begin
    off       = addr_q[1:0];
    word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    case (size_q)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    case (size_q)
      2'd0:    rep_wdata = {4{wdata_q[7:0]}};
      2'd1:    rep_wdata = {2{wdata_q[15:0]}};
      default: rep_wdata = wdata_q;
    endcase
  end

`ifdef MISALIGN_SPLIT_EN
  logic        mis_q;
  logic [31:0] lo_q;
  logic [7:0]  lane_mask;
  logic [63:0] shift_wdata;

  // Lanes/data spanning two words; the upper half belongs to the second beat
  assign lane_mask   = {4'b0000, size_mask} << off;
  assign shift_wdata = {32'b0, wdata_q} << {off, 3'b000};
  // A halfword at offset 1 fits in one word, so only a real spill needs beat 1
  assign last_beat   = !((state == ACCESS) && mis_q && (lane_mask[7:4] != 4'b0000));
`else
  assign last_beat   = 1'b1;
`endif

  // Move the addressed lane(s) down to bit 0, then sign/zero extend
  always_comb begin
    raw = bus_rdata >> {off, 3'b000};
`ifdef MISALIGN_SPLIT_EN
    if (state == ACCESS1)
      raw = lo_q | (bus_rdata << (6'd32 - {1'b0, off, 3'b000}));
`endif
    case (size_q)
      2'd0:    ext = uns_q ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    ext = uns_q ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and outputs; the bus is driven only while a beat is in flight
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_be     = 4'b0000;
    bus_wdata  = 32'b0;
    case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
`ifdef MISALIGN_SPLIT_EN
          state_next = ACCESS;
`else
          state_next = misalign_in ? RESP : ACCESS;
`endif
        end
      end
      ACCESS: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = rw_q;
        bus_addr  = word_addr;
        bus_be    = size_mask << off;
        bus_wdata = rep_wdata;
`ifdef MISALIGN_SPLIT_EN
        if (mis_q) begin
          bus_be    = lane_mask[3:0];
          bus_wdata = shift_wdata[31:0];
        end
        if (bus_ack)      state_next = last_beat ? RESP : ACCESS1;
        else if (timeout) state_next = RESP;
`else
        if (bus_ack || timeout) state_next = RESP;
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      ACCESS1: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = rw_q;
        bus_addr  = word_addr + ADDR_W'(4);
        bus_be    = lane_mask[7:4];
        bus_wdata = shift_wdata[63:32];
        if (bus_ack || timeout) state_next = RESP;
      end
`endif
      RESP: begin
        done       = 1'b1;
        err        = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, per-beat timeout counter and load result register
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      cnt     <= 8'd0;
`ifdef MISALIGN_SPLIT_EN
      mis_q   <= 1'b0;
      lo_q    <= 32'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rw_q    <= mem_rw;
            size_q  <= size_in;
            uns_q   <= load_op[2];
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= 8'd0;
`ifdef MISALIGN_SPLIT_EN
            mis_q   <= misalign_in;
            err_q   <= 1'b0;
`else
            err_q   <= misalign_in;
`endif
          end
        end
        RESP: ;
        // Any bus beat: an ack in the timeout cycle still completes cleanly
        default: begin
          if (bus_ack) begin
            cnt <= 8'd0;
            if (last_beat && !rw_q) rdata_q <= ext;
`ifdef MISALIGN_SPLIT_EN
            if (!last_beat) lo_q <= raw;
`endif
          end else if (timeout) begin
            cnt   <= 8'd0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the instruction decoder's memory controls (MemRW, load_op, write_op) and a ready/ack data-memory bus.
- Generates word-aligned bus requests with byte enables and lane-replicated store data.
- Stalls the core until the access completes.
- Returns a sign- or zero-extended load result, and flags misaligned or timed-out accesses.

Parameters:
ADDR_W, 32, address width
TIMEOUT_CYC, 255, max ACCESS cycles waiting for bus_ack before abort (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  memory instruction present in execute
mem_rw  in  1  0=load, 1=store
load_op  in  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; 3/6/7 treated as LW
write_op  in  2  0 SB, 1 SH, 2/3 SW
addr  in  ADDR_W  effective address (rs1+imm)
wdata  in  32  store data (rs2)
stall  out  1  hold PC/pipeline
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result
err  out  1  one-cycle pulse with done on misalign/timeout
bus_req  out  1  bus request
bus_we  out  1  write strobe
bus_addr  out  ADDR_W  word address, [1:0]=0
bus_be  out  4  byte enables
bus_wdata  out  32  lane-aligned store data
bus_ack  in  1  access complete; bus_rdata valid this cycle
bus_rdata  in  32  read data

Behaviour:
- Reset: clk is the single clock; rst is synchronous and active-high.
- Reset state: IDLE; stall, done, err, bus_req, bus_we all 0; bus_addr, bus_be, bus_wdata, rdata 0; timeout counter 0.
- rst mid-access: bus_req drops the next cycle; no done is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, req_valid=1:
  - Latch mem_rw, op, addr, wdata.
  - Aligned access → ACCESS.
  - Misaligned access → RESP with err pending.
- Misalignment definition: halfword with addr[0]=1; word with addr[1:0]≠0. Bytes are never misaligned.
- ACCESS:
  - bus_req=1, with bus_we/bus_addr/bus_be/bus_wdata held stable until bus_ack.
  - On bus_ack: latch extended load data (loads only) → RESP.
  - Counter increments each ACCESS cycle. If counter reaches TIMEOUT_CYC with no ack: drop bus_req, set err pending → RESP.
  - Ack in the same cycle as timeout: ack wins, no err.
- RESP: done=1 and err=pending for one cycle; stall=0; → IDLE. req_valid is ignored in RESP.
- stall = (IDLE & req_valid) | ACCESS. It is never asserted in RESP.
- Minimum latency: accept at cycle 0, ACCESS at cycle 1; ack at cycle 1 gives done at cycle 2.
- Byte enables:
  - SB/LB/LBU: 1<<addr[1:0].
  - SH/LH/LHU: addr[1] ? 1100 : 0011.
  - Word: 1111.
- Store data: SB replicates byte ×4; SH replicates halfword ×2; SW passes through.
- Load extraction: select lane by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- rdata:
  - Updated only on a successful load ack.
  - Holds its value across stores, errors and idle.
  - Timed-out or misaligned loads leave rdata unchanged.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined:
  - Misaligned halfword/word accesses run as two beats, via states ACCESS0 then ACCESS1.
  - Beat 0: word at addr&~3, enables for the upper lanes.
  - Beat 1: word at (addr&~3)+4 (wraps 0xFFFFFFFC→0x00000000), enables for the remaining lanes.
  - Load bytes are merged across beats before extension; store data is shifted across both beats.
  - Timeout applies per beat. A timeout on beat 1 aborts with err; the beat-0 store is not rolled back.
  - err is never raised for misalignment.
- Undefined: misaligned access gives err+done in RESP with no bus activity.

Test Plan:
- LW addr=0x100, ack on 1st ACCESS cycle, bus_rdata=0xDEADBEEF → bus_addr=0x100, be=1111, done at cycle 2, rdata=0xDEADBEEF, stall high cycles 0–1.
- LB addr=0x103, bus_rdata=0x80FF_FFFF → be=1000, rdata=0xFFFFFF80; the same access as LBU → rdata=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, ack after 3 wait cycles → bus_we=1, be=1100, bus_wdata=0xABCDABCD held 4 cycles, done once, rdata unchanged.
- SW addr=0x301 → without the macro: no bus_req, done+err at cycle 1. With MISALIGN_SPLIT_EN: beats to 0x300 (be=1110) then 0x304 (be=0001).
- LW with bus_ack never asserted, TIMEOUT_CYC=4 → bus_req high 4 cycles then low, done+err pulse, rdata unchanged. Repeat with ack on the 4th cycle → no err.
- rst asserted during ACCESS → next cycle bus_req=0, stall=0, no done. A subsequent LHU addr=0x2, bus_rdata=0xFFFE0000 → rdata=0x0000FFFE.
